// File: rtl/avalon_pio_poller_pkg.sv
// Shared types for the Avalon PIO poller: FSM state encoding, bus data type
// and the PIO data-register offset.
package avalon_pio_pkg;

  localparam logic [2:0] ST_ENC_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENC_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_ENC_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_ENC_EVAL    = 3'd3;
  localparam logic [2:0] ST_ENC_WR_REQ  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_ENC_IDLE,
    ST_RD_REQ  = ST_ENC_RD_REQ,
    ST_RD_WAIT = ST_ENC_RD_WAIT,
    ST_EVAL    = ST_ENC_EVAL,
    ST_WR_REQ  = ST_ENC_WR_REQ
  } poller_state_e;

  typedef logic [31:0] avm_data_t;

  localparam logic [31:0] PIO_DATA_OFFSET = 32'd0;

  // Byte address of the data register of a PIO mapped at the given base.
  function automatic logic [31:0] pio_data_addr(input logic [31:0] base);
    return base + PIO_DATA_OFFSET;
  endfunction

endpackage

// File: rtl/avalon_pio_poller_if.sv
// Avalon-MM initiator bus between the poller and its PIO responders.
interface avalon_pio_poller_if #(
  parameter int ADDR_W = 16
);
  import avalon_pio_pkg::*;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  avm_data_t         avm_writedata;
  logic              avm_waitrequest;
  avm_data_t         avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );

endinterface

// File: rtl/avalon_pio_poller_debounce.sv
// pio_debounce_ctr: counts consecutive identical samples and flags a change
// only once the new value has been seen DEBOUNCE_CNT times in a row.
module pio_debounce_ctr
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] ref_value,
  output logic             accept
);

  localparam int            CW      = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);

  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] last_r;

  // Stability counter: restart at 1 on a new value, saturate at CNT_MAX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r  <= '0;
      last_r <= '0;
    end else if (load) begin
      last_r <= sample;
      if (sample != last_r) begin
        cnt_r <= CW'(1);
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r  <= cnt_r;
      last_r <= last_r;
    end
  end

  assign accept = (last_r != ref_value) && (cnt_r == CNT_MAX);

endmodule

// File: rtl/avalon_pio_poller.sv
// Avalon-MM initiator that polls an input PIO and mirrors changes to an output PIO.
// Build option: define POLLER_DEBOUNCE_EN to require DEBOUNCE_CNT stable samples.
module avalon_pio_poller
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int ADDR_W       = 16,
  parameter int SRC_ADDR     = 0,
  parameter int DST_ADDR     = 16,
  parameter int POLL_PERIOD  = 50000,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  avalon_pio_poller_if.master  avm,
  output logic [WIDTH-1:0]     sw_value,
  output logic                 change_pulse,
  output logic                 busy
);

  localparam int               CNT_W    = $clog2(POLL_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_PERIOD - 1);
  localparam logic [ADDR_W-1:0] SRC_A   = ADDR_W'(pio_data_addr(32'(SRC_ADDR)));
  localparam logic [ADDR_W-1:0] DST_A   = ADDR_W'(pio_data_addr(32'(DST_ADDR)));

  poller_state_e     state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r, cnt_next_s;
  logic              first_r, first_next_s;
  logic [WIDTH-1:0]  sample_r, sample_next_s;
  logic [WIDTH-1:0]  sw_value_r, sw_next_s;
  logic              change_r, change_next_s;
  logic [ADDR_W-1:0] addr_r, addr_next_s;
  logic              rd_r, rd_next_s;
  logic              wr_r, wr_next_s;
  avm_data_t         wdata_r, wdata_next_s;
  logic              busy_r, busy_next_s;
  logic              sample_load_s;
  logic              accept_s;
  logic              unused_rdata_s;

`ifdef POLLER_DEBOUNCE_EN
  pio_debounce_ctr #(
    .WIDTH        (WIDTH),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (sample_load_s),
    .sample    (sample_next_s),
    .ref_value (sw_value_r),
    .accept    (accept_s)
  );
`else
  logic unused_debounce_cfg_s;
  assign unused_debounce_cfg_s = (DEBOUNCE_CNT != 0) && sample_load_s;
  assign accept_s = (sample_r != sw_value_r);
`endif

  // Upper read-data bits carry nothing we use.
  assign unused_rdata_s = ^avm.avm_readdata;

  // Next-state logic; bus outputs are decoded from the next state and registered.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    first_next_s  = first_r;
    sample_next_s = sample_r;
    sw_next_s     = sw_value_r;
    change_next_s = 1'b0;
    sample_load_s = 1'b0;
    rd_next_s     = 1'b0;
    wr_next_s     = 1'b0;
    busy_next_s   = 1'b0;
    addr_next_s   = '0;
    wdata_next_s  = '0;

    case (state_r)
      ST_IDLE: begin
        if (!enable) begin
          cnt_next_s = '0;
        end else if (cnt_r == CNT_LAST) begin
          cnt_next_s   = '0;
          state_next_s = ST_RD_REQ;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RD_REQ: begin
        if (!avm.avm_waitrequest) state_next_s = ST_RD_WAIT;
        else                      state_next_s = ST_RD_REQ;
      end
      ST_RD_WAIT: begin
        if (avm.avm_readdatavalid) begin
          sample_next_s = avm.avm_readdata[WIDTH-1:0];
          sample_load_s = 1'b1;
          state_next_s  = ST_EVAL;
        end else begin
          state_next_s = ST_RD_WAIT;
        end
      end
      ST_EVAL: begin
        // first_r forces one write after reset so the output PIO is in sync.
        if (first_r || accept_s) begin
          sw_next_s     = sample_r;
          change_next_s = 1'b1;
          first_next_s  = 1'b0;
          state_next_s  = ST_WR_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        if (!avm.avm_waitrequest) state_next_s = ST_IDLE;
        else                      state_next_s = ST_WR_REQ;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    rd_next_s   = (state_next_s == ST_RD_REQ);
    wr_next_s   = (state_next_s == ST_WR_REQ);
    busy_next_s = (state_next_s != ST_IDLE);

    if (rd_next_s) begin
      addr_next_s = SRC_A;
    end else if (wr_next_s) begin
      addr_next_s = DST_A;
    end else begin
      addr_next_s = '0;
    end

    if (wr_next_s) begin
      wdata_next_s[WIDTH-1:0] = sw_next_s;
    end else begin
      wdata_next_s = '0;
    end
  end

  // State, period counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      first_r    <= 1'b1;
      sample_r   <= '0;
      sw_value_r <= '0;
      change_r   <= 1'b0;
      addr_r     <= '0;
      rd_r       <= 1'b0;
      wr_r       <= 1'b0;
      wdata_r    <= '0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      first_r    <= first_next_s;
      sample_r   <= sample_next_s;
      sw_value_r <= sw_next_s;
      change_r   <= change_next_s;
      addr_r     <= addr_next_s;
      rd_r       <= rd_next_s;
      wr_r       <= wr_next_s;
      wdata_r    <= wdata_next_s;
      busy_r     <= busy_next_s;
    end
  end

  assign avm.avm_address   = addr_r;
  assign avm.avm_read      = rd_r;
  assign avm.avm_write     = wr_r;
  assign avm.avm_writedata = wdata_r;
  assign sw_value          = sw_value_r;
  assign change_pulse      = change_r;
  assign busy              = busy_r;

endmodule
